// File: rtl/exp2_pkg.sv
// Shared definitions for the power-of-two generator.
//   POW_W   : exponent width
//   NUM_W   : result width (2**POW_W), one-hot result
//   state_t : handshake/shift controller states
package exp2_pkg;

    localparam int POW_W = 3;
    localparam int NUM_W = 1 << POW_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/exp2_gen.sv
// exp2_gen: computes 2**n as a one-hot word by shifting a single set bit
// left n times, one position per clock. Inverse of the power-of-two to
// exponent encoder: out_number encodes back to out_pow.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : exponent offered
//   in_pow     : exponent n
//   in_ready   : block is idle and can accept an exponent
//   out_valid  : result available
//   out_number : result 2**n (one-hot)
//   out_pow    : exponent captured at accept
//   out_ready  : consumer accepts the result
module exp2_gen #(
    parameter int POW_W = 3,
    parameter int NUM_W = 2 ** POW_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [POW_W-1:0] in_pow,
    output logic             in_ready,
    output logic             out_valid,
    output logic [NUM_W-1:0] out_number,
    output logic [POW_W-1:0] out_pow,
    input  logic             out_ready
);

    import exp2_pkg::*;

    state_t           state;
    logic [NUM_W-1:0] acc;
    logic [POW_W-1:0] cnt;
    logic [POW_W-1:0] pow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            pow_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is the IDLE decode, so in_valid alone is the handshake here
                    if (in_valid) begin
                        acc   <= NUM_W'(1);
                        cnt   <= in_pow;
                        pow_q <= in_pow;
                        state <= (in_pow == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc << 1;
                    cnt <= cnt - 1'b1;
                    // last shift happens on this edge when one step remains
                    if (cnt == POW_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_number = acc;
    assign out_pow    = pow_q;

endmodule

// File: tb/tb_exp2_gen.sv
// Self-checking bench for exp2_gen: a driver issues exponents and pushes
// the expected result (2**n, n, accept cycle) into a scoreboard queue; a
// monitor on the falling edge checks every valid result cycle against the
// queue head and pops on each completed transfer.
module tb_exp2_gen;

    localparam int POW_W = 3;
    localparam int NUM_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [POW_W-1:0] in_pow;
    logic             in_ready;
    logic             out_valid;
    logic [NUM_W-1:0] out_number;
    logic [POW_W-1:0] out_pow;
    logic             out_ready;

    exp2_gen #(.POW_W(POW_W), .NUM_W(NUM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_pow     (in_pow),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_number (out_number),
        .out_pow    (out_pow),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  num;
        int          t0;
    } item_t;

    item_t q[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit    seen     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoder: bit position of the single set bit, -1 if none, -2 if several.
    function automatic int encode(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) begin
            if (v[i] === 1'b1) r = (r == -1) ? i : -2;
        end
        return r;
    endfunction

    task automatic push(input int n, input int t0);
        item_t it;
        it.n   = n;
        it.num = 8'(2 ** n);
        it.t0  = t0;
        q.push_back(it);
    endtask

    // One clock: record a handshake that will happen at the coming edge,
    // then advance and drive out_ready for the next cycle.
    task automatic step();
        if (rst_n && in_valid && in_ready) push(int'(in_pow), cyc + 1);
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic offer(input int n);
        int g = 0;
        forever begin
            in_valid = 1'b1;
            in_pow   = POW_W'(n);
            if (in_ready) begin
                step();
                break;
            end
            step();
            g++;
            if (g > 500) begin
                $display("FAIL offer_timeout: got in_ready=0 expected 1 within 500 cycles");
                $fatal(1, "offer timeout");
            end
        end
        in_valid = 1'b0;
    endtask

    // Idle cycles; while busy, wiggle in_valid/in_pow to show they are ignored.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_pow   = POW_W'($urandom);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!out_valid) begin
            step();
            g++;
            if (g > 100) begin
                $display("FAIL wait_valid: got out_valid=0 expected 1 within 100 cycles");
                $fatal(1, "wait_valid timeout");
            end
        end
    endtask

    task automatic reset_pulse();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_number", out_number, 0);
        check("rst_out_pow",    out_pow,    0);
        check("rst_in_ready",   in_ready,   1);
        q.delete();
        step();
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
    endtask

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
            check("in_reset_out_valid", out_valid, 0);
        end else begin
            if (in_ready && out_valid) check("ready_valid_overlap", 1, 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_result", out_valid, 0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc, q[0].t0 + q[0].n);
                        seen = 1;
                    end
                    check("out_number", out_number, q[0].num);
                    check("out_pow",    out_pow,    q[0].n);
                    check("round_trip", encode(out_number), out_pow);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end else if (q.size() > 0 && cyc > q[0].t0 + q[0].n) begin
                check("result_late", out_valid, 1);
                void'(q.pop_front());
                seen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pow    = '0;
        out_ready = 1'b1;
        #3;
        check("reset_in_ready",   in_ready,   1);
        check("reset_out_valid",  out_valid,  0);
        check("reset_out_number", out_number, 0);
        check("reset_out_pow",    out_pow,    0);
        #9;
        rst_n = 1'b1;

        // n=0 right after reset release, accepted on the first edge
        rdy_mode = 1;
        check("first_accept_ready", in_ready, 1);
        offer(0);
        step();
        check("ready_after_n0", in_ready, 1);
        idle(2);

        // n=5 with consumer ready
        offer(5);
        idle(8);

        // n=7 with 10 cycles of backpressure after DONE
        rdy_mode  = 0;
        out_ready = 1'b0;
        offer(7);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_in_ready", in_ready, 0);
            check("bp_valid",    out_valid, 1);
        end
        rdy_mode = 1;
        idle(3);

        // in_pow changed and in_valid held high while busy
        offer(3);
        in_valid = 1'b1;
        in_pow   = 3'd6;
        offer(6);
        idle(10);

        // reset mid-shift
        offer(6);
        step();
        step();
        step();
        reset_pulse();
        offer(2);
        idle(6);

        // reset while holding a result in DONE
        rdy_mode  = 0;
        out_ready = 1'b0;
        offer(1);
        wait_valid();
        step();
        reset_pulse();
        rdy_mode = 1;
        offer(4);
        idle(8);

        // back-to-back sweep with random consumer readiness
        rdy_mode = 2;
        for (int n = 0; n < 8; n++) offer(n);

        // random exponents and gaps
        for (int k = 0; k < 40; k++) begin
            offer(int'($urandom_range(0, 7)));
            idle(int'($urandom_range(0, 12)));
        end

        // drain
        rdy_mode = 1;
        begin
            int g = 0;
            while (q.size() != 0 && g < 200) begin
                idle(1);
                g++;
            end
        end
        check("drained", q.size(), 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
